// File: rtl/k_fifo_pkg.sv
// Shared constants and helpers for the FIFO pointer/flag controller.
package k_fifo_pkg;

   localparam int FIFO_RST_PTR   = 0;
   localparam int FIFO_DEF_ASIZE = 1;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(input int asize);
      return asize + 1;
   endfunction

endpackage

// File: rtl/k_fifo_ptr.sv
// Wrap counter used for both the write and read pointers.
// Width is addr_size+1; the MSB is the wrap bit that separates full from empty.
module k_fifo_ptr
   import k_fifo_pkg::*;
#(
   parameter int addr_size = FIFO_DEF_ASIZE
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          inc,
   output logic [ptr_w(addr_size)-1:0]   ptr
);

   localparam int PW = ptr_w(addr_size);

   logic [PW-1:0] r_ptr;

   // Advance by one on inc, with natural binary rollover.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= PW'(FIFO_RST_PTR);
      end else if (inc) begin
         r_ptr <= r_ptr + PW'(1);
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/k_fifo_2deep_ctrl.sv
// Pointer and flag controller for a small show-ahead FIFO built on a
// dual-port RAM with combinational read. Drives the RAM write enable and
// addresses, decodes full/empty/count from the pointers and keeps sticky
// overflow/underflow flags.
module k_fifo_2deep_ctrl
   import k_fifo_pkg::*;
#(
   parameter int addr_size = FIFO_DEF_ASIZE
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 clr_err,
   output logic                 wen,
   output logic [addr_size-1:0] waddr,
   output logic [addr_size-1:0] raddr,
   output logic                 full,
   output logic                 empty,
   output logic [addr_size:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int PW = ptr_w(addr_size);

   logic [PW-1:0] w_wptr;
   logic [PW-1:0] w_rptr;
   logic          w_pop_ok;
   logic          w_push_ok;
   logic          w_ovf_set;
   logic          w_unf_set;
   logic          r_overflow;
   logic          r_underflow;

   // A pop frees the slot in the same edge, so a full FIFO may still accept
   // a push alongside it; an empty FIFO never lets a push fall through.
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);
   assign w_ovf_set = push && !w_push_ok;
   assign w_unf_set = pop && !w_pop_ok;

   k_fifo_ptr #(.addr_size(addr_size)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_push_ok),
      .ptr   (w_wptr)
   );

   k_fifo_ptr #(.addr_size(addr_size)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_pop_ok),
      .ptr   (w_rptr)
   );

   // Flags and addresses decode straight from the registered pointers.
   assign empty = (w_wptr == w_rptr);
   assign full  = (w_wptr[addr_size-1:0] == w_rptr[addr_size-1:0]) &&
                  (w_wptr[addr_size] != w_rptr[addr_size]);
   assign count = w_wptr - w_rptr;
   assign waddr = w_wptr[addr_size-1:0];
   assign raddr = w_rptr[addr_size-1:0];

   // Gate with rst_n so no RAM write can slip through while held in reset.
   assign wen = w_push_ok && rst_n;

   // Sticky error flags; a fresh error in the clearing cycle wins over clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_set || (r_overflow  && !clr_err);
         r_underflow <= w_unf_set || (r_underflow && !clr_err);
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
